arm_multicycle_controller: RTL and testbench
============================================

# arm_multicycle_controller

Finite-state controller that sequences the ARM32 multicycle datapath, which shares one ALU and one memory port across instruction phases. Each instruction is split into 2–5 cycles. The controller:
- decodes the latched instruction fields;
- evaluates the condition code against an internal NZCV flag register;
- drives every datapath select and write-enable for each phase.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state FETCH and clears the flag register
- Cond  in  4  Instr[31:28] from the instruction register
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: I, cmd[3:0], S (or L for memory ops)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  live ALU flags {N,Z,C,V}
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data reg, 10 = ALUResult
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- RegWrite  out  1  register file write enable

## Operation

**States.** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH. A one-bit CondExReg and a 4-bit Flags register hold state across phases.

**Transitions.**
- FETCH → DECODE, always.
- DECODE → FETCH if CondEx is false or Op==11.
- DECODE → MEMADR if Op==01.
- DECODE → EXECUTEI if Op==00 and Funct[5]=1.
- DECODE → EXECUTER if Op==00 and Funct[5]=0.
- DECODE → BRANCH if Op==10.
- MEMADR → MEMRD if Funct[0] (load); otherwise → MEMWR.
- MEMRD → MEMWB.
- EXECUTER and EXECUTEI → ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH → FETCH.

**Per-state outputs.** Unlisted selects are 00; unlisted enables are 0; ALUControl is ADD unless stated.
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 1, ALUSrcB 10, ResultSrc 10, PCWrite 1.
- DECODE: ALUSrcA 1, ALUSrcB 10, ResultSrc 10. This computes PC+8 for R15 reads.
- MEMADR: ALUSrcA 0, ALUSrcB 01.
- MEMRD: AdrSrc 1.
- MEMWB: ResultSrc 01, RegWrite.
- MEMWR: AdrSrc 1, MemWrite.
- EXECUTER: ALUSrcA 0, ALUSrcB 00, ALUControl decoded.
- EXECUTEI: ALUSrcA 0, ALUSrcB 01, ALUControl decoded.
- ALUWB: ResultSrc 00, RegWrite unless the command is CMP. If Rd==15, also PCWrite.
- BRANCH: ALUSrcA 0, ALUSrcB 01, ResultSrc 10, PCWrite.

**ALU decode.** The command is cmd = Funct[4:1].
- ADD (0100) → 00.
- SUB (0010) → 01.
- CMP (1010) → 01.
- AND (0000) → 10.
- ORR (1100) → 11.
- Any other cmd → 00, and writeback is suppressed (same as CMP).

**Condition evaluation.** Cond is evaluated combinationally in DECODE against Flags and captured into CondExReg at the end of DECODE.
- EQ: Z. NE: !Z.
- CS: C. CC: !C.
- MI: N. PL: !N.
- VS: V. VC: !V.
- HI: C&!Z. LS: !C|Z.
- GE: N==V. LT: N!=V.
- GT: !Z&(N==V). LE: Z|(N!=V).
- AL (1110): true. 1111: false.

**Write gating.** In all states after DECODE, RegWrite, MemWrite and PCWrite are ANDed with CondExReg. FETCH is ungated.

**Flag update.** At the end of EXECUTER or EXECUTEI, when S=1 and CondExReg=1:
- Flags[3:2] ← ALUFlags[3:2].
- Flags[1:0] are also updated only for ADD, SUB or CMP.
- For AND and ORR, C and V are kept.

## Timing
- Reset (asynchronous): state becomes FETCH and Flags become 0000 immediately. While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- First FETCH occurs on the first rising edge after reset deasserts.
- Cycles per instruction:
  - skipped or undefined: 2
  - branch: 3
  - STR: 4
  - data-processing: 4
  - LDR: 5
- All outputs are Moore-style, decoded from the current state and the latched instruction fields only; there is no combinational path from ALUFlags to any output.
- Flags written at the end of instruction k are visible to the DECODE of instruction k+1.
- Reset asserted mid-instruction aborts it. No write enable is asserted after reset rises.

## Test plan
- Reset release, then ADD R1,R2,#5 (Op 00, Funct 101000) → states FETCH, DECODE, EXECUTEI, ALUWB. RegWrite=1 only in ALUWB. ALUSrcB=01 in EXECUTEI.
- SUBS (Funct 000101) with ALUFlags=0100 in EXECUTER, then BEQ (Cond 0000, Op 10) → Flags=0100. BRANCH asserts PCWrite with ResultSrc=10. The instruction takes 3 cycles.
- BNE with Z=1 → DECODE returns to FETCH. PCWrite asserted only in FETCH. The instruction takes 2 cycles.
- LDR (Op 01, Funct[0]=1) → MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1). STR → MEMWR with MemWrite=1 and RegWrite=0.
- CMP, then ADD to Rd=15 in ALUWB → CMP never asserts RegWrite. The ADD asserts both RegWrite and PCWrite.
- Assert reset during MEMWR → MemWrite drops to 0 immediately. After release, the state is FETCH and Flags=0000.

Source files
------------

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM32 controller: sequences fetch/decode/execute phases over a
// shared ALU and memory port, evaluates condition codes against an internal
// NZCV register and drives every datapath select and write enable.
module arm_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBranch
  } state_e;

  state_e     state_q, state_d;
  logic       cond_ex_q, cond_ex;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cmd;
  logic [1:0] alu_dec;
  logic       no_wb;      // command produces flags only (CMP or unsupported)
  logic       cv_update;  // arithmetic command, so C and V are meaningful

  logic       flag_n, flag_z, flag_c, flag_v;

  logic       pcw_raw, mw_raw, rw_raw, irw_raw;
  logic       gated;

  assign cmd = Funct[4:1];
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

  // Decode the data-processing command into ALU operation and writeback policy
  always_comb begin
    alu_dec   = 2'b00;
    no_wb     = 1'b1;
    cv_update = 1'b0;
    case (cmd)
      4'b0100: begin alu_dec = 2'b00; no_wb = 1'b0; cv_update = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; no_wb = 1'b0; cv_update = 1'b1; end
      4'b1010: begin alu_dec = 2'b01; no_wb = 1'b1; cv_update = 1'b1; end
      4'b0000: begin alu_dec = 2'b10; no_wb = 1'b0; end
      4'b1100: begin alu_dec = 2'b11; no_wb = 1'b0; end
      default: begin alu_dec = 2'b00; no_wb = 1'b1; end
    endcase
  end

  // Evaluate the condition field against the stored flags
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Condition latch and NZCV flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_ex_q <= 1'b0;
      flags_q   <= 4'b0000;
    end else begin
      if (state_q == StDecode) begin
        cond_ex_q <= cond_ex;
      end
      flags_q <= flags_d;
    end
  end

  // Flag update at the end of an execute phase of a flag-setting instruction
  always_comb begin
    flags_d = flags_q;
    if ((state_q == StExecuteR || state_q == StExecuteI) && Funct[0] && cond_ex_q) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cv_update) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (!cond_ex || Op == 2'b11) begin
          state_d = StFetch;
        end else begin
          case (Op)
            2'b01:   state_d = StMemAdr;
            2'b00:   state_d = Funct[5] ? StExecuteI : StExecuteR;
            2'b10:   state_d = StBranch;
            default: state_d = StFetch;
          endcase
        end
      end
      StMemAdr:   state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:    state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Per-state Moore outputs with condition gating and reset override
  always_comb begin
    pcw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    irw_raw    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    gated      = 1'b1;
    case (state_q)
      StFetch: begin
        gated     = 1'b0;
        irw_raw   = 1'b1;
        pcw_raw   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        gated     = 1'b0;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
      end
      StMemRd: begin
        AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        rw_raw    = 1'b1;
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        mw_raw = 1'b1;
      end
      StExecuteR: begin
        ALUControl = alu_dec;
      end
      StExecuteI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      StAluWb: begin
        rw_raw  = ~no_wb;
        // A write to R15 is a PC write; it follows the register writeback
        pcw_raw = ~no_wb & (Rd == 4'd15);
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw_raw   = 1'b1;
      end
      default: begin
        gated = 1'b1;
      end
    endcase

    PCWrite  = pcw_raw & (~gated | cond_ex_q) & ~reset;
    MemWrite = mw_raw  & (~gated | cond_ex_q) & ~reset;
    RegWrite = rw_raw  & (~gated | cond_ex_q) & ~reset;
    IRWrite  = irw_raw & ~reset;
  end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Randomized self-checking bench for arm_multicycle_controller. Each
// instruction is expanded into its expected phase list by a behavioural model
// and every cycle's full control vector is compared.
module tb_arm_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  int vectors;
  int miscompares;

  logic [3:0] flags_m;  // model NZCV

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] alu;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic       rw;
  } ctl_t;

  typedef enum {PhFetch, PhDecode, PhMemAdr, PhMemRd, PhMemWb, PhMemWr,
                PhExecR, PhExecI, PhAluWb, PhBranch} phase_e;

  arm_multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .Op        (Op),
    .Funct     (Funct),
    .Rd        (Rd),
    .ALUFlags  (ALUFlags),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .RegWrite  (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t observed();
    ctl_t o;
    o = '{pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite, rs: ResultSrc, sa: ALUSrcA,
          sb: ALUSrcB, alu: ALUControl, imm: ImmSrc, regsrc: RegSrc, rw: RegWrite};
    return o;
  endfunction

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Operation code the ALU should receive for a data-processing command
  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit writes_back(input logic [3:0] cmd);
    return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
  endfunction

  function automatic ctl_t expect_ctl(input phase_e ph, input logic [1:0] op,
                                      input logic [5:0] funct, input logic [3:0] rd);
    ctl_t e;
    e = '0;
    e.imm    = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    case (ph)
      PhFetch:  begin e.irw = 1; e.pcw = 1; e.sa = 1; e.sb = 2'b10; e.rs = 2'b10; end
      PhDecode: begin e.sa = 1; e.sb = 2'b10; e.rs = 2'b10; end
      PhMemAdr: e.sb = 2'b01;
      PhMemRd:  e.adr = 1;
      PhMemWb:  begin e.rs = 2'b01; e.rw = 1; end
      PhMemWr:  begin e.adr = 1; e.mw = 1; end
      PhExecR:  e.alu = alu_of(funct[4:1]);
      PhExecI:  begin e.sb = 2'b01; e.alu = alu_of(funct[4:1]); end
      PhAluWb:  begin
        e.rw  = writes_back(funct[4:1]);
        e.pcw = writes_back(funct[4:1]) && rd == 4'd15;
      end
      default:  begin e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1; end
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH; call just after a rising edge
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] aflags);
    phase_e ph[$];
    bit     ce;
    ctl_t   exp_c, got;
    Cond = c; Op = op; Funct = funct; Rd = rd; ALUFlags = aflags;
    ce = cond_holds(c, flags_m);
    ph.push_back(PhFetch);
    ph.push_back(PhDecode);
    if (ce) begin
      case (op)
        2'b00: begin
          ph.push_back(funct[5] ? PhExecI : PhExecR);
          ph.push_back(PhAluWb);
        end
        2'b01: begin
          ph.push_back(PhMemAdr);
          if (funct[0]) begin
            ph.push_back(PhMemRd);
            ph.push_back(PhMemWb);
          end else begin
            ph.push_back(PhMemWr);
          end
        end
        2'b10: ph.push_back(PhBranch);
        default: ;
      endcase
    end
    foreach (ph[i]) begin
      @(negedge clk);
      exp_c = expect_ctl(ph[i], op, funct, rd);
      got   = observed();
      vectors++;
      if (got !== exp_c) begin
        miscompares++;
        $display("FAIL %s cycle %0d (phase %s): got %h expected %h", name, i, ph[i].name(),
                 got, exp_c);
      end
      @(posedge clk);
      #1;
    end
    if (ce && op == 2'b00 && funct[0]) begin
      flags_m[3:2] = aflags[3:2];
      if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010 || funct[4:1] == 4'b1010)
        flags_m[1:0] = aflags[1:0];
    end
  endtask

  task automatic test_reset();
    ctl_t exp_c;
    reset = 1'b1;
    Cond = 4'hE; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; ALUFlags = 4'b0;
    flags_m = 4'b0;
    @(negedge clk);
    vectors++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_enables: got %b expected 0000",
               {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    exp_c = expect_ctl(PhFetch, Op, Funct, Rd);
    vectors++;
    if (observed() !== exp_c) begin
      miscompares++;
      $display("FAIL reset_release_fetch: got %h expected %h", observed(), exp_c);
    end
  endtask

  task automatic test_add_imm();
    run_instr("add_imm", 4'hE, 2'b00, 6'b101000, 4'd1, 4'($urandom));
  endtask

  task automatic test_subs_beq();
    run_instr("subs", 4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);
    run_instr("beq_taken", 4'h0, 2'b10, 6'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic test_bne_skip();
    run_instr("bne_skip", 4'h1, 2'b10, 6'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic test_ldr_str();
    run_instr("ldr", 4'hE, 2'b01, 6'b011001, 4'd4, 4'($urandom));
    run_instr("str", 4'hE, 2'b01, 6'b011000, 4'd5, 4'($urandom));
  endtask

  task automatic test_cmp_add_pc();
    run_instr("cmp", 4'hE, 2'b00, 6'b010101, 4'd3, 4'b0010);
    run_instr("add_pc", 4'hE, 2'b00, 6'b001000, 4'd15, 4'($urandom));
  endtask

  task automatic test_reset_mid_memwr();
    ctl_t exp_c;
    // Leave N and Z set so a missing flag clear is visible afterwards
    run_instr("subs_nz", 4'hE, 2'b00, 6'b000101, 4'd6, 4'b1100);
    Cond = 4'hE; Op = 2'b01; Funct = 6'b010000; Rd = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (MemWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL memwr_before_reset: got MemWrite=%b expected 1", MemWrite);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_memwr: got %b expected 0000",
               {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    flags_m = 4'b0000;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    exp_c = expect_ctl(PhFetch, Op, Funct, Rd);
    vectors++;
    if (observed() !== exp_c) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: got %h expected %h", observed(), exp_c);
    end
    run_instr("beq_after_reset", 4'h0, 2'b10, 6'b0, 4'd0, 4'($urandom));
    run_instr("bmi_after_reset", 4'h4, 2'b10, 6'b0, 4'd0, 4'($urandom));
    run_instr("bpl_after_reset", 4'h5, 2'b10, 6'b0, 4'd0, 4'($urandom));
  endtask

  task automatic test_random();
    logic [3:0] c, rd;
    logic [5:0] f;
    for (int k = 0; k < 400; k++) begin
      c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      f  = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: f[4:1] = 4'b0100;
          1: f[4:1] = 4'b0010;
          2: f[4:1] = 4'b1010;
          3: f[4:1] = 4'b0000;
          default: f[4:1] = 4'b1100;
        endcase
      end
      rd = 4'($urandom);
      if (!writes_back(f[4:1]) && rd == 4'd15) rd = 4'($urandom_range(0, 14));
      run_instr("random", c, 2'($urandom), f, rd, 4'($urandom));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    Cond = 4'h0; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; ALUFlags = 4'b0;
    flags_m     = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add_imm();
    test_subs_beq();
    test_bne_skip();
    test_ldr_str();
    test_cmp_add_pc();
    test_reset_mid_memwr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
